processor_switch_debounce: RTL and testbench

//  Conditions the raw slide-switch inputs before they reach the switches PIO.

---
 rtl/processor_switch_debounce.sv | 81 ++++++++
 tb/tb_processor_switch_debounce.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/processor_switch_debounce.sv
// rtl/processor_switch_debounce.sv - two-flop synchronizer plus stable-time debounce for slide switches
//
// Conditions raw slide-switch levels before they reach the switches PIO.
// Each bit is synchronized through two flops and then has to hold a new
// level for STABLE_CYCLES consecutive cycles before sw_db follows it.
//
// Ports:
//   clk         system clock, shared with the PIO
//   reset       synchronous, active-high reset
//   sw_raw      asynchronous raw switch levels from the pins
//   sw_db       debounced levels, drives the PIO in_port
//   sw_changed  per-bit one-cycle pulse when the matching sw_db bit updates
//   any_change  OR of sw_changed, registered on the same edge
module processor_switch_debounce #(
    parameter int WIDTH         = 10,
    parameter int STABLE_CYCLES = 50000,
    parameter int CNT_W         = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] sw_raw,
    output logic [WIDTH-1:0] sw_db,
    output logic [WIDTH-1:0] sw_changed,
    output logic             any_change
);

    // Count value on which the N-th consecutive differing sample is seen.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [WIDTH-1:0] s1;
    logic [WIDTH-1:0] s2;
    logic [CNT_W-1:0] cnt      [WIDTH];
    logic [CNT_W-1:0] cnt_next [WIDTH];
    logic [WIDTH-1:0] db_next;
    logic [WIDTH-1:0] chg_next;

    // Per-bit filter. A sample equal to the current debounced level clears
    // the count, so any bounce back restarts the qualification window.
    // Reaching the last count accepts the level and clears the counter,
    // which therefore never wraps.
    always_comb begin
        db_next  = sw_db;
        chg_next = '0;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_next[i] = '0;
            if (s2[i] != sw_db[i]) begin
                if (cnt[i] == CNT_LAST) begin
                    db_next[i]  = s2[i];
                    chg_next[i] = 1'b1;
                end else begin
                    cnt_next[i] = cnt[i] + CNT_ONE;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1         <= '0;
            s2         <= '0;
            sw_db      <= '0;
            sw_changed <= '0;
            any_change <= 1'b0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            s1         <= sw_raw;
            s2         <= s1;
            sw_db      <= db_next;
            sw_changed <= chg_next;
            // Built from the next-state pulses so it lines up with sw_changed.
            any_change <= |chg_next;
            for (int i = 0; i < WIDTH; i++) begin
                cnt[i] <= cnt_next[i];
            end
        end
    end

endmodule

// File: tb/tb_processor_switch_debounce.sv
// tb/tb_processor_switch_debounce.sv - self-checking bench for processor_switch_debounce
module tb_processor_switch_debounce;

    localparam int W    = 10;
    localparam int N    = 8;
    localparam int MAXE = 8192;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [W-1:0] sw_raw = '0;
    logic [W-1:0] sw_db;
    logic [W-1:0] sw_changed;
    logic         any_change;

    int tests_run    = 0;
    int tests_failed = 0;

    processor_switch_debounce #(
        .WIDTH(W),
        .STABLE_CYCLES(N),
        .CNT_W(4)
    ) dut (
        .clk(clk),
        .reset(reset),
        .sw_raw(sw_raw),
        .sw_db(sw_db),
        .sw_changed(sw_changed),
        .any_change(any_change)
    );

    always #5 clk = ~clk;

    // Reference model: keeps the full history of sampled inputs and decides
    // each bit from a sliding window. The filter at edge u looks at the value
    // sampled at edge u-2 (zero if reset hit edge u-1 or u-2). A bit flips at
    // edge t when, for all N edges u in [t-N+1, t], there was no reset and
    // that delayed sample differed from the current debounced level.
    logic [W-1:0] raw_h [MAXE];
    bit           rst_h [MAXE];
    int           edge_n = 0;
    logic [W-1:0] m_db  = '0;
    logic [W-1:0] m_chg = '0;
    logic         m_any = 1'b0;

    always @(posedge clk) begin
        bit ok;
        int u;
        raw_h[edge_n] = sw_raw;
        rst_h[edge_n] = reset;
        m_chg = '0;
        if (reset) begin
            m_db = '0;
        end else begin
            for (int i = 0; i < W; i++) begin
                ok = 1'b1;
                for (int k = 0; k < N; k++) begin
                    u = edge_n - k;
                    if (u < 2) ok = 1'b0;
                    else if (rst_h[u] || rst_h[u-1] || rst_h[u-2]) ok = 1'b0;
                    else if (raw_h[u-2][i] == m_db[i]) ok = 1'b0;
                end
                if (ok) begin
                    m_db[i]  = ~m_db[i];
                    m_chg[i] = 1'b1;
                end
            end
        end
        m_any = |m_chg;
        if (edge_n < MAXE - 1) edge_n++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset  = 1'b1;
        sw_raw = 10'h3FF;
        for (int k = 0; k < 3; k++) begin
            tick();
            tests_run++;
            if (sw_db !== '0 || sw_changed !== '0 || any_change !== 1'b0) begin
                tests_failed++;
                $display("FAIL reset_outputs cycle %0d: db=%h chg=%h any=%b required all 0",
                         k, sw_db, sw_changed, any_change);
            end
        end
        reset = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            tick();
            tests_run++;
            if (sw_db !== m_db || sw_changed !== m_chg || any_change !== m_any) begin
                tests_failed++;
                $display("FAIL reset_model edge %0d: db=%h chg=%h any=%b required db=%h chg=%h any=%b",
                         k, sw_db, sw_changed, any_change, m_db, m_chg, m_any);
            end
            if (k == 9) begin
                tests_run++;
                if (sw_db !== 10'h000) begin
                    tests_failed++;
                    $display("FAIL reset_rise_early edge 9: db=%h required 000", sw_db);
                end
            end
            if (k == 10) begin
                tests_run++;
                if (sw_db !== 10'h3FF || any_change !== 1'b1) begin
                    tests_failed++;
                    $display("FAIL reset_rise edge 10: db=%h any=%b required 3ff 1", sw_db, any_change);
                end
            end
            if (k == 11) begin
                tests_run++;
                if (any_change !== 1'b0 || sw_changed !== 10'h000) begin
                    tests_failed++;
                    $display("FAIL reset_pulse_width edge 11: chg=%h any=%b required 000 0",
                             sw_changed, any_change);
                end
            end
        end
    endtask

    task automatic test_single_rise();
        reset  = 1'b1;
        sw_raw = '0;
        tick();
        tick();
        reset = 1'b0;
        for (int k = 0; k < 12; k++) tick();
        sw_raw = 10'h001;
        for (int k = 1; k <= 12; k++) begin
            tick();
            tests_run++;
            if (sw_db !== m_db || sw_changed !== m_chg || any_change !== m_any) begin
                tests_failed++;
                $display("FAIL single_model edge %0d: db=%h chg=%h required db=%h chg=%h",
                         k - 1, sw_db, sw_changed, m_db, m_chg);
            end
            if (k == 9) begin
                tests_run++;
                if (sw_db !== 10'h000) begin
                    tests_failed++;
                    $display("FAIL single_early E0+8: db=%h required 000", sw_db);
                end
            end
            if (k == 10) begin
                tests_run++;
                if (sw_db !== 10'h001 || sw_changed !== 10'h001) begin
                    tests_failed++;
                    $display("FAIL single_rise E0+9: db=%h chg=%h required 001 001", sw_db, sw_changed);
                end
            end
            if (k == 11) begin
                tests_run++;
                if (sw_changed !== 10'h000) begin
                    tests_failed++;
                    $display("FAIL single_pulse_width E0+10: chg=%h required 000", sw_changed);
                end
            end
        end
    endtask

    task automatic test_short_pulse();
        int pulses;
        pulses = 0;
        sw_raw = 10'h009;
        for (int k = 0; k < 7; k++) begin
            tick();
            if (sw_changed !== '0) pulses++;
        end
        sw_raw = 10'h001;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (sw_changed !== '0) pulses++;
            tests_run++;
            if (sw_db !== 10'h001 || sw_db !== m_db) begin
                tests_failed++;
                $display("FAIL short_pulse_db cycle %0d: db=%h required 001 (model %h)", k, sw_db, m_db);
            end
        end
        tests_run++;
        if (pulses != 0) begin
            tests_failed++;
            $display("FAIL short_pulse_chg: %0d pulses seen, required 0", pulses);
        end
    endtask

    task automatic test_bounce();
        sw_raw = 10'h021; tick();
        sw_raw = 10'h001; tick();
        sw_raw = 10'h021; tick();
        sw_raw = 10'h001; tick();
        sw_raw = 10'h021;
        for (int k = 1; k <= 12; k++) begin
            tick();
            tests_run++;
            if (sw_db !== m_db || sw_changed !== m_chg) begin
                tests_failed++;
                $display("FAIL bounce_model edge %0d: db=%h chg=%h required db=%h chg=%h",
                         k - 1, sw_db, sw_changed, m_db, m_chg);
            end
            if (k == 9) begin
                tests_run++;
                if (sw_db !== 10'h001) begin
                    tests_failed++;
                    $display("FAIL bounce_early F+8: db=%h required 001", sw_db);
                end
            end
            if (k == 10) begin
                tests_run++;
                if (sw_db !== 10'h021 || sw_changed !== 10'h020) begin
                    tests_failed++;
                    $display("FAIL bounce_rise F+9: db=%h chg=%h required 021 020", sw_db, sw_changed);
                end
            end
        end
    endtask

    task automatic test_simultaneous();
        int any_pulses;
        any_pulses = 0;
        sw_raw = 10'h225;
        for (int k = 1; k <= 14; k++) begin
            tick();
            if (any_change === 1'b1) any_pulses++;
            tests_run++;
            if (sw_db !== m_db || sw_changed !== m_chg || any_change !== m_any) begin
                tests_failed++;
                $display("FAIL simul_model edge %0d: db=%h chg=%h any=%b required db=%h chg=%h any=%b",
                         k - 1, sw_db, sw_changed, any_change, m_db, m_chg, m_any);
            end
            if (k == 10) begin
                tests_run++;
                if (sw_db !== 10'h225 || sw_changed !== 10'h204 || any_change !== 1'b1) begin
                    tests_failed++;
                    $display("FAIL simul_rise E0+9: db=%h chg=%h any=%b required 225 204 1",
                             sw_db, sw_changed, any_change);
                end
            end
        end
        tests_run++;
        if (any_pulses != 1) begin
            tests_failed++;
            $display("FAIL simul_any_count: %0d any_change pulses, required 1", any_pulses);
        end
    endtask

    task automatic test_reset_midcount();
        sw_raw = 10'h2A5;
        for (int k = 0; k < 7; k++) tick();
        tests_run++;
        if (sw_db !== 10'h225) begin
            tests_failed++;
            $display("FAIL midcount_pending: db=%h required 225", sw_db);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            tick();
            tests_run++;
            if (sw_db !== m_db || sw_changed !== m_chg || any_change !== m_any) begin
                tests_failed++;
                $display("FAIL midcount_model edge %0d: db=%h chg=%h required db=%h chg=%h",
                         k, sw_db, sw_changed, m_db, m_chg);
            end
            if (k == 9) begin
                tests_run++;
                if (sw_db !== 10'h000) begin
                    tests_failed++;
                    $display("FAIL midcount_early edge 9: db=%h required 000", sw_db);
                end
            end
            if (k == 10) begin
                tests_run++;
                if (sw_db !== 10'h2A5 || sw_changed !== 10'h2A5) begin
                    tests_failed++;
                    $display("FAIL midcount_rise edge 10: db=%h chg=%h required 2a5 2a5", sw_db, sw_changed);
                end
            end
        end
    endtask

    task automatic test_random();
        int hold;
        int errs;
        errs = 0;
        for (int seg = 0; seg < 220; seg++) begin
            if ($urandom_range(0, 24) == 0) begin
                reset = 1'b1;
                hold  = $urandom_range(1, 2);
            end else begin
                reset = 1'b0;
                if ($urandom_range(0, 2) == 0) sw_raw = sw_raw ^ (W'(1) << $urandom_range(0, W - 1));
                else sw_raw = sw_raw ^ W'($urandom_range(0, 1023));
                hold = $urandom_range(1, 12);
            end
            for (int k = 0; k < hold; k++) begin
                tick();
                tests_run++;
                if (sw_db !== m_db || sw_changed !== m_chg || any_change !== m_any) begin
                    tests_failed++;
                    errs++;
                    if (errs < 10)
                        $display("FAIL random_model seg %0d: db=%h chg=%h any=%b required db=%h chg=%h any=%b",
                                 seg, sw_db, sw_changed, any_change, m_db, m_chg, m_any);
                end
            end
        end
        reset = 1'b0;
        for (int k = 0; k < 14; k++) begin
            tick();
            tests_run++;
            if (sw_db !== m_db || sw_changed !== m_chg || any_change !== m_any) begin
                tests_failed++;
                $display("FAIL random_settle cycle %0d: db=%h chg=%h required db=%h chg=%h",
                         k, sw_db, sw_changed, m_db, m_chg);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_rise();
        test_short_pulse();
        test_bounce();
        test_simultaneous();
        test_reset_midcount();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
